// File: rtl/adc_resp_emu_if.sv
// adc_resp_emu_if: command/response streaming bus between an ADC initiator and the emulator
interface adc_resp_emu_if;
  logic        command_valid;
  logic        command_ready;
  logic [4:0]  command_channel;
  logic        command_startofpacket;
  logic        command_endofpacket;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        response_startofpacket;
  logic        response_endofpacket;
  modport master (
    output command_valid, command_channel, command_startofpacket, command_endofpacket,
    input  command_ready, response_valid, response_channel, response_data,
           response_startofpacket, response_endofpacket
  );
  modport slave (
    input  command_valid, command_channel, command_startofpacket, command_endofpacket,
    output command_ready, response_valid, response_channel, response_data,
           response_startofpacket, response_endofpacket
  );
endinterface

// File: rtl/adc_resp_emu.sv
// adc_resp_emu: emulates an ADC that answers channel commands from a loadable sample table
module adc_resp_emu #(
  parameter int CONV_CYCLES = 4,
  parameter int MAX_CH      = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  adc_resp_emu_if.slave       bus,
  input  logic                load_en,
  input  logic [4:0]          load_channel,
  input  logic [11:0]         load_data,
  output logic                cmd_error,
  output logic [15:0]         conv_count
);
  typedef enum logic [1:0] {IDLE, CONVERT, RESPOND} state_t;
  localparam logic [7:0] CNT_INIT = 8'(CONV_CYCLES - 1);
  localparam logic [5:0] CH_MAX   = 6'(MAX_CH);
  state_t      state;
  logic [7:0]  cnt;
  logic [4:0]  ch;
  logic [11:0] table_mem [32];
  logic        ready_q;
  logic        valid_q;
  logic [4:0]  rsp_ch;
  logic [11:0] rsp_data;
  logic [15:0] done_cnt;
  logic        accept;
  logic        unused_sop_eop;
  assign accept                     = bus.command_valid && ready_q;
  assign bus.command_ready          = ready_q;
  assign bus.response_valid         = valid_q;
  assign bus.response_startofpacket = valid_q;
  assign bus.response_endofpacket   = valid_q;
  assign bus.response_channel       = rsp_ch;
  assign bus.response_data          = rsp_data;
  assign conv_count                 = done_cnt;
  assign unused_sop_eop             = bus.command_startofpacket ^ bus.command_endofpacket;
  // sample table: cleared on reset, written by the load port; reads in the FSM see the pre-edge value
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) table_mem[i] <= '0;
    end else if (load_en) begin
      table_mem[load_channel] <= load_data;
    end
  end
  // conversion FSM with registered handshake, result and status outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ch        <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      rsp_ch    <= '0;
      rsp_data  <= '0;
      cmd_error <= 1'b0;
      done_cnt  <= '0;
    end else begin
      valid_q   <= 1'b0;
      cmd_error <= accept && ({1'b0, bus.command_channel} > CH_MAX);
      if (accept) begin
        state   <= CONVERT;
        cnt     <= CNT_INIT;
        ch      <= bus.command_channel;
        ready_q <= 1'b0;
      end else if (state == CONVERT) begin
        cnt <= cnt - 8'd1;
        if (cnt == 8'd0) begin
          state    <= RESPOND;
          ready_q  <= 1'b1;
          valid_q  <= 1'b1;
          rsp_ch   <= ch;
          rsp_data <= ({1'b0, ch} > CH_MAX) ? 12'h000 : table_mem[ch];
          done_cnt <= done_cnt + 16'd1;
        end
      end else if (state == RESPOND) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_adc_resp_emu.sv
// tb_adc_resp_emu: directed scoreboard bench for the ADC response emulator
module tb_adc_resp_emu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  adc_resp_emu_if bus ();
  adc_resp_emu_if bus1 ();
  logic        load_en;
  logic [4:0]  load_channel;
  logic [11:0] load_data;
  logic        cmd_error, cmd_error1;
  logic [15:0] conv_count, conv_count1;
  adc_resp_emu dut (
    .Clk(clk), .Reset(rst), .bus(bus),
    .load_en(load_en), .load_channel(load_channel), .load_data(load_data),
    .cmd_error(cmd_error), .conv_count(conv_count)
  );
  adc_resp_emu #(.CONV_CYCLES(1)) dut1 (
    .Clk(clk), .Reset(rst), .bus(bus1),
    .load_en(1'b0), .load_channel(5'd0), .load_data(12'h000),
    .cmd_error(cmd_error1), .conv_count(conv_count1)
  );
  typedef struct {
    logic [4:0]  ch;
    logic [11:0] data;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [11:0] mdl [32];
  logic [15:0] mcnt;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction
  // response scoreboard: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (bus.response_valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = q.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_channel", bus.response_channel, e.ch);
        chk("rsp_data", bus.response_data, e.data);
        chk("rsp_count", conv_count, e.cnt);
        chk("rsp_sop", bus.response_startofpacket, 1);
        chk("rsp_eop", bus.response_endofpacket, 1);
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load(input logic [4:0] c, input logic [11:0] d);
    load_en = 1'b1;
    load_channel = c;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    mdl[c] = d;
  endtask
  task automatic cmd(input logic [4:0] c);
    bus.command_valid = 1'b1;
    bus.command_channel = c;
    @(negedge clk);
    bus.command_valid = 1'b0;
    mcnt++;
    q.push_back('{c, (c > 5'd16) ? 12'h000 : mdl[c], mcnt, cyc + 4});
  endtask
  initial begin
    int n, lows;
    bus.command_valid = 1'b0;
    bus.command_channel = '0;
    bus.command_startofpacket = 1'b0;
    bus.command_endofpacket = 1'b0;
    bus1.command_valid = 1'b0;
    bus1.command_channel = '0;
    bus1.command_startofpacket = 1'b0;
    bus1.command_endofpacket = 1'b0;
    load_en = 1'b0;
    load_channel = '0;
    load_data = '0;
    mcnt = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    idle(2);
    chk("rst_ready", bus.command_ready, 1);
    chk("rst_valid", bus.response_valid, 0);
    chk("rst_sop", bus.response_startofpacket, 0);
    chk("rst_eop", bus.response_endofpacket, 0);
    chk("rst_channel", bus.response_channel, 0);
    chk("rst_data", bus.response_data, 0);
    chk("rst_cmd_error", cmd_error, 0);
    chk("rst_count", conv_count, 0);
    rst = 1'b0;
    @(negedge clk);
    load(5'd1, 12'h7FF);
    cmd(5'd1);
    chk("legal_no_error", cmd_error, 0);
    idle(6);
    chk("single_done", q.size(), 0);
    load(5'd3, 12'h123);
    bus.command_valid = 1'b1;
    bus.command_channel = 5'd3;
    @(negedge clk);
    n = cyc;
    for (int k = 0; k < 3; k++) begin
      mcnt++;
      q.push_back('{5'd3, 12'h123, mcnt, n + 4 + 5 * k});
    end
    lows = (bus.command_ready === 1'b0) ? 1 : 0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (bus.command_ready === 1'b0) lows++;
      if (j == 10) bus.command_valid = 1'b0;
    end
    idle(2);
    chk("b2b_ready_low", lows, 12);
    chk("b2b_done", q.size(), 0);
    chk("b2b_count", conv_count, 4);
    cmd(5'd20);
    chk("oor_error_pulse", cmd_error, 1);
    @(negedge clk);
    chk("oor_error_clear", cmd_error, 0);
    idle(5);
    load(5'd16, 12'h3C3);
    cmd(5'd16);
    chk("max_ch_no_error", cmd_error, 0);
    idle(6);
    load(5'd17, 12'hABC);
    cmd(5'd17);
    chk("max_ch_plus1_error", cmd_error, 1);
    idle(6);
    load(5'd2, 12'h555);
    cmd(5'd2);
    idle(3);
    load(5'd2, 12'hAAA);
    idle(3);
    cmd(5'd2);
    idle(6);
    chk("load_race_done", q.size(), 0);
    bus.command_valid = 1'b1;
    bus.command_channel = 5'd1;
    @(negedge clk);
    bus.command_valid = 1'b0;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mcnt = '0;
    chk("abort_ready", bus.command_ready, 1);
    idle(8);
    chk("abort_count", conv_count, 0);
    cmd(5'd1);
    idle(6);
    chk("abort_table_cleared", q.size(), 0);
    force dut.done_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.done_cnt;
    mcnt = 16'hFFFE;
    @(negedge clk);
    cmd(5'd3);
    idle(5);
    cmd(5'd3);
    idle(6);
    chk("wrap_count", conv_count, 16'h0000);
    bus1.command_valid = 1'b1;
    bus1.command_channel = 5'd5;
    @(negedge clk);
    bus1.command_valid = 1'b0;
    chk("c1_ready_low", bus1.command_ready, 0);
    chk("c1_not_yet", bus1.response_valid, 0);
    @(negedge clk);
    chk("c1_valid", bus1.response_valid, 1);
    chk("c1_channel", bus1.response_channel, 5);
    chk("c1_data", bus1.response_data, 0);
    chk("c1_count", conv_count1, 1);
    @(negedge clk);
    chk("c1_valid_clear", bus1.response_valid, 0);
    chk("all_responses_seen", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
